// File: rtl/core_pkg.sv
// Shared types and default constants for the 16-bit core pipeline.
package core_pkg;

    typedef enum logic [1:0] {
        PS_RUN,
        PS_DRAIN,
        PS_HALTED
    } pipe_state_t;

    localparam int unsigned PIPE_DRAIN_CYCLES = 2;
    localparam int unsigned PIPE_CNT_W        = 16;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stage enables/flushes for load-use stalls, mispredict flushes,
// external freezes and the halt drain, plus saturating stall/flush event counters.
module pipe_ctrl
    import core_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = PIPE_DRAIN_CYCLES,
    parameter int unsigned CNT_W        = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       rs_id,
    input  logic [2:0]       rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic [2:0]       regwrite_adr_ex,
    input  logic             regwrite_ex,
    input  logic             from_main_mem_ex,
    input  logic             jump_pred_miss,
    input  logic             is_halt_ex,
    input  logic             ext_stall,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exmem,
    output logic             en_memwb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             flush_memwb,
    output logic             flushed,
    output logic             is_halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    pipe_state_t   state_q;
    logic [DW-1:0] drain_q;
    logic          flushed_q;
    logic          is_halt_q;

    logic [4:0] en;  // {pc, ifid, idex, exmem, memwb}
    logic [3:0] fl;  // {ifid, idex, exmem, memwb}
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    assign load_use = from_main_mem_ex & regwrite_ex &
                      ((use_rs_id & (rs_id == regwrite_adr_ex)) |
                       (use_rt_id & (rt_id == regwrite_adr_ex)));

    always_comb begin
        en        = 5'b11111;
        fl        = 4'b0000;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (!reset || ext_stall) begin
            en = 5'b00000;
        end else begin
            unique case (state_q)
                PS_RUN: begin
                    if (is_halt_ex) begin
                        // HLT is squashed before MEM; older work in MEM/WB still retires.
                        en = 5'b01111;
                        fl = 4'b1110;
                    end else if (jump_pred_miss) begin
                        fl        = 4'b1100;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        en        = 5'b00111;
                        fl        = 4'b0100;
                        stall_inc = 1'b1;
                    end
                end
                PS_DRAIN: begin
                    en = 5'b00111;
                    fl = 4'b0110;
                end
                default: en = 5'b00000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= PS_RUN;
            drain_q   <= '0;
            flushed_q <= 1'b0;
            is_halt_q <= 1'b0;
        end else begin
            flushed_q <= flush_inc;
            unique case (state_q)
                PS_RUN: begin
                    if (!ext_stall && is_halt_ex) begin
                        state_q <= PS_DRAIN;
                        drain_q <= DW'(DRAIN_CYCLES);
                    end
                end
                PS_DRAIN: begin
                    if (!ext_stall) begin
                        if (drain_q <= DW'(1)) begin
                            state_q   <= PS_HALTED;
                            is_halt_q <= 1'b1;
                            drain_q   <= '0;
                        end else begin
                            drain_q <= drain_q - DW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign {en_pc, en_ifid, en_idex, en_exmem, en_memwb}      = en;
    assign {flush_ifid, flush_idex, flush_exmem, flush_memwb} = fl;
    assign flushed = flushed_q;
    assign is_halt = is_halt_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a rule-level model.
module tb_pipe_ctrl;

    localparam int unsigned DRAIN = 2;
    localparam int unsigned CW    = 16;
    localparam int unsigned CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    rs_id, rt_id, regwrite_adr_ex;
    logic          use_rs_id, use_rt_id, regwrite_ex, from_main_mem_ex;
    logic          jump_pred_miss, is_halt_ex, ext_stall;
    logic          en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic          flush_ifid, flush_idex, flush_exmem, flush_memwb;
    logic          flushed, is_halt;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .DRAIN_CYCLES (DRAIN),
        .CNT_W        (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rs_id            (rs_id),
        .rt_id            (rt_id),
        .use_rs_id        (use_rs_id),
        .use_rt_id        (use_rt_id),
        .regwrite_adr_ex  (regwrite_adr_ex),
        .regwrite_ex      (regwrite_ex),
        .from_main_mem_ex (from_main_mem_ex),
        .jump_pred_miss   (jump_pred_miss),
        .is_halt_ex       (is_halt_ex),
        .ext_stall        (ext_stall),
        .en_pc            (en_pc),
        .en_ifid          (en_ifid),
        .en_idex          (en_idex),
        .en_exmem         (en_exmem),
        .en_memwb         (en_memwb),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .flush_exmem      (flush_exmem),
        .flush_memwb      (flush_memwb),
        .flushed          (flushed),
        .is_halt          (is_halt),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: unbounded event counts (clipped when compared), halt countdown in cycles.
    int unsigned m_stall, m_flush;
    bit          m_flushed, m_halted;
    int          m_drain_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int unsigned clip(input int unsigned v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic bit lu();
        return from_main_mem_ex && regwrite_ex &&
               ((use_rs_id && rs_id == regwrite_adr_ex) || (use_rt_id && rt_id == regwrite_adr_ex));
    endfunction

    task automatic m_clear();
        m_stall = 0; m_flush = 0; m_flushed = 0; m_halted = 0; m_drain_left = 0;
    endtask

    task automatic exp_outs(output logic [4:0] e, output logic [3:0] f);
        e = 5'b11111; f = 4'b0000;
        if (!reset || m_halted || ext_stall) e = 5'b00000;
        else if (m_drain_left > 0) begin e = 5'b00111; f = 4'b0110; end
        else if (is_halt_ex)       begin e = 5'b01111; f = 4'b1110; end
        else if (jump_pred_miss)   f = 4'b1100;
        else if (lu())             begin e = 5'b00111; f = 4'b0100; end
    endtask

    task automatic check_all();
        logic [4:0] e;
        logic [3:0] f;
        exp_outs(e, f);
        chk("enables", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, e);
        chk("flushes", {flush_ifid, flush_idex, flush_exmem, flush_memwb}, f);
        chk("flushed", flushed, m_flushed);
        chk("is_halt", is_halt, m_halted);
        chk("stall_cnt", stall_cnt, clip(m_stall));
        chk("flush_cnt", flush_cnt, clip(m_flush));
    endtask

    task automatic settle_check();
        #2;
        check_all();
    endtask

    task automatic tick();
        bit running, ext, h, m, l;
        running = !m_halted && m_drain_left == 0;
        ext = ext_stall; h = is_halt_ex; m = jump_pred_miss; l = lu();
        @(posedge clk);
        if (!reset) m_clear();
        else begin
            m_flushed = running && !ext && !h && m;
            if (running && !ext) begin
                if (h) m_drain_left = DRAIN;
                else if (m) m_flush++;
                else if (l) m_stall++;
            end else if (m_drain_left > 0 && !ext) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        rs_id = 0; rt_id = 0; regwrite_adr_ex = 0; use_rs_id = 0; use_rt_id = 0;
        regwrite_ex = 0; from_main_mem_ex = 0; jump_pred_miss = 0; is_halt_ex = 0; ext_stall = 0;
    endtask

    task automatic set_lu(input bit use_rs);
        idle();
        from_main_mem_ex = 1; regwrite_ex = 1; regwrite_adr_ex = 3; rs_id = 3; use_rs_id = use_rs;
    endtask

    task automatic do_reset();
        reset = 0;
        m_clear();
        idle();
        settle_check();
        tick();
        reset = 1;
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    initial begin
        reset = 1;
        idle();
        m_clear();
        @(posedge clk);
        #1;

        // Reset state and default outputs after release
        do_reset();
        settle_check();
        chk("default_en", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 5'b11111);
        tick();

        // Load-use stall, then the same with use_rs_id=0
        set_lu(1);
        settle_check();
        chk("lu_en_pc", en_pc, 0);
        chk("lu_flush_idex", flush_idex, 1);
        tick();
        set_lu(0);
        settle_check();
        chk("lu_stall_cnt", stall_cnt, 1);
        chk("no_lu_en_ifid", en_ifid, 1);
        tick();

        // Misprediction; flushed pulses one cycle; then miss plus load-use
        idle(); jump_pred_miss = 1;
        step();
        idle();
        settle_check();
        chk("miss_flushed", flushed, 1);
        chk("miss_flush_cnt", flush_cnt, 1);
        tick();
        set_lu(1); jump_pred_miss = 1;
        step();
        idle();
        settle_check();
        chk("miss_lu_stall_cnt", stall_cnt, 1);
        tick();
        settle_check();
        chk("flushed_one_cycle", flushed, 0);
        tick();

        // Halt at t: is_halt at t+1+DRAIN; everything stays frozen afterwards
        do_reset();
        idle(); is_halt_ex = 1;
        settle_check();
        chk("halt_flush_exmem", flush_exmem, 1);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            settle_check();
            chk("drain_en_memwb", en_memwb, 1);
            chk("drain_not_halted", is_halt, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_lu(1); jump_pred_miss = 1; is_halt_ex = 1;
            settle_check();
            chk("halted_is_halt", is_halt, 1);
            chk("halted_en", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 0);
            tick();
        end

        // ext_stall during drain stretches the halt by the stall length
        do_reset();
        idle(); is_halt_ex = 1;
        step();
        idle(); ext_stall = 1;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("drain_freeze_en", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 0);
            tick();
        end
        idle();
        step();
        settle_check();
        chk("stretched_not_halted", is_halt, 0);
        tick();
        settle_check();
        chk("stretched_halted", is_halt, 1);
        tick();

        // Asynchronous reset mid-drain
        do_reset();
        idle(); is_halt_ex = 1;
        step();
        idle();
        #2;
        reset = 0;
        m_clear();
        #1;
        chk("async_rst_en", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 0);
        chk("async_rst_fl", {flush_ifid, flush_idex, flush_exmem, flush_memwb}, 0);
        tick();
        reset = 1;
        settle_check();
        chk("post_rst_default", {en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 5'b11111);
        tick();

        // Randomized traffic including rare halts and resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) begin
                reset = 0;
                m_clear();
            end else begin
                reset = 1;
            end
            rs_id            = 3'($urandom_range(7));
            rt_id            = 3'($urandom_range(7));
            regwrite_adr_ex  = 3'($urandom_range(7));
            use_rs_id        = 1'($urandom_range(1));
            use_rt_id        = 1'($urandom_range(1));
            regwrite_ex      = ($urandom_range(3) != 0);
            from_main_mem_ex = 1'($urandom_range(1));
            jump_pred_miss   = ($urandom_range(7) == 0);
            ext_stall        = ($urandom_range(7) == 0);
            is_halt_ex       = ($urandom_range(149) == 0);
            step();
        end

        // Stall counter saturation
        do_reset();
        set_lu(1);
        repeat (65541) tick();
        settle_check();
        chk("stall_cnt_saturated", stall_cnt, 16'hFFFF);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the 5-stage 16-bit core. It owns every stage enable and flush (`en_pc`, `en_ifid`/`flush_ifid` through `en_memwb`/`flush_memwb`) and sequences four behaviours:
- load-use stalls
- jump-misprediction flushes
- external freezes
- the halt drain into a terminal halted state

It also keeps saturating stall and flush counters for performance bring-up.

## Interface
Parameters:
- `DRAIN_CYCLES`, 2, cycles spent draining MEM/WB after a halt leaves EX
- `CNT_W`, 16, width of the performance counters

Ports:
- `clk`  in  1  clock. One clock domain; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset
- `rs_id`, `rt_id`  in  3 each  source register fields of the instruction in ID
- `use_rs_id`, `use_rt_id`  in  1 each  the ID instruction actually reads that source
- `regwrite_adr_ex`  in  3  destination register of the EX instruction
- `regwrite_ex`  in  1  EX instruction writes a register
- `from_main_mem_ex`  in  1  EX instruction is a load
- `jump_pred_miss`  in  1  EX resolved a mispredicted jump; the redirect PC is valid this cycle
- `is_halt_ex`  in  1  EX instruction is HLT
- `ext_stall`  in  1  freeze the whole pipeline this cycle
- `en_pc`, `en_ifid`, `en_idex`, `en_exmem`, `en_memwb`  out  1 each  stage register enables
- `flush_ifid`, `flush_idex`, `flush_exmem`, `flush_memwb`  out  1 each  load a bubble into that stage register
- `flushed`  out  1  registered; high for exactly 1 cycle after a misprediction flush
- `is_halt`  out  1  registered; core halted
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters

## Operation
The FSM has three states: `RUN`, `DRAIN`, `HALTED`. The state resets to `RUN`.

Definitions:
- **Default:** all `en_*`=1 and all `flush_*`=0.
- **load_use:** `from_main_mem_ex & regwrite_ex & ((use_rs_id & rs_id==regwrite_adr_ex) | (use_rt_id & rt_id==regwrite_adr_ex))`.

RUN, evaluated in priority order (the first matching rule applies):
1. `ext_stall` (freeze):
   - all `en_*`=0, all `flush_*`=0
   - no counter update, no state change
2. `is_halt_ex`:
   - `en_pc`=0
   - `flush_ifid`=1, `flush_idex`=1, `flush_exmem`=1, so HLT does not enter MEM
   - load the drain counter with `DRAIN_CYCLES`; next state `DRAIN`
3. `jump_pred_miss`:
   - `en_pc`=1 to take the redirect
   - `flush_ifid`=1, `flush_idex`=1
   - `flush_cnt`+1; `flushed` goes to 1 next cycle
4. `load_use`:
   - `en_pc`=0, `en_ifid`=0, `flush_idex`=1
   - `en_exmem`=1, `en_memwb`=1
   - `stall_cnt`+1
5. Otherwise: Default.

DRAIN:
- Outputs: `en_pc`=0, `en_ifid`=0, `flush_idex`=1, `flush_exmem`=1, `en_memwb`=1.
- If `ext_stall`: all `en_*`=0, all `flush_*`=0, and the drain counter holds.
- Otherwise the drain counter decrements. At 1→0, next state `HALTED` and `is_halt` goes to 1 next cycle.
- `jump_pred_miss`, `is_halt_ex` and `load_use` are ignored.

HALTED:
- All `en_*`=0, all `flush_*`=0.
- `is_halt`=1 permanently; only reset exits this state.
- All inputs are ignored.

Counters:
- `stall_cnt` and `flush_cnt` saturate at all-ones (no wrap).
- `stall_cnt` counts only load-use stall cycles; ext_stall cycles are not counted.

## Timing
- Enables and flushes are combinational from the current state and same-cycle inputs; there is no added latency.
- `flushed`, `is_halt`, the counters and the state are registered.
- A load-use stall lasts exactly 1 cycle, because the load moves to MEM on the next edge.
- A halt asserted in cycle t gives `is_halt`=1 from cycle t+1+`DRAIN_CYCLES`.
- `ext_stall` held for N cycles extends that by N.
- While `reset`=0: all `en_*`=0, all `flush_*`=0, `is_halt`=0, `flushed`=0, counters 0, state `RUN`.
  - This holds even mid-DRAIN or in HALTED.
- Reset deassertion takes effect at the next `clk` edge.
- A miss and a load-use in the same cycle: the miss wins, and `stall_cnt` is not incremented.
- A halt and a miss in the same cycle: the halt wins, and `flush_cnt` is not incremented.

## Structure
- Shared package `core_pkg`:
  - `typedef enum logic [1:0] {PS_RUN, PS_DRAIN, PS_HALTED} pipe_state_t`
  - default constants `PIPE_DRAIN_CYCLES`=2 and `PIPE_CNT_W`=16
- One sub-module `sat_counter`, parameterized by width, with inputs `inc` and reset. It is instantiated twice, for the stall and flush counts.
- Hazard compare, priority mux and FSM stay in `pipe_ctrl`.

## Test plan
- **Load-use:** `from_main_mem_ex`=1, `regwrite_ex`=1, `regwrite_adr_ex`=3, `rs_id`=3, `use_rs_id`=1 → `en_pc`=`en_ifid`=0 and `flush_idex`=1 for 1 cycle; `stall_cnt` 0→1. The same stimulus with `use_rs_id`=0 → Default outputs.
- **Misprediction:** `jump_pred_miss`=1 for 1 cycle → `flush_ifid`=`flush_idex`=1 and `en_pc`=1; `flushed`=1 next cycle only; `flush_cnt`=1. Miss plus load-use together → `stall_cnt` unchanged.
- **Halt:** `is_halt_ex`=1 at cycle 10 → `flush_exmem`=1 at 10; `en_memwb`=1 at 11–12; `is_halt`=1 at 13. Afterwards all enables stay 0 regardless of inputs.
- **ext_stall in DRAIN:** halt at cycle 10, `ext_stall`=1 at 11–13 → `is_halt`=1 at 16; all enables 0 during 11–13.
- **Async reset:** drive `reset`=0 mid-DRAIN between clock edges → outputs clear immediately. Release → state RUN with Default outputs.
- **Saturation:** force 2^16+5 load-use cycles → `stall_cnt`=16'hFFFF, no wrap.
